// File: rtl/posit_pkg.sv
// posit_pkg: shared posit parameters, helpers and decoder state encoding
// reused by the decoder, alignment and later arithmetic stages.
package posit_pkg;
   function automatic int log2(input int x);
      int r = 0;
      while ((1 << r) < x) r++;
      return r;
   endfunction
   localparam int N_DEF  = 8;
   localparam int ES_DEF = 3;
   localparam int MANT_W = N_DEF - ES_DEF + 3;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SCAN    = 2'd1,
      EXTRACT = 2'd2,
      DONE    = 2'd3
   } dec_state_e;
endpackage

// File: rtl/posit_regime_scanner.sv
// posit_regime_scanner: walks the regime run of one operand one bit per clock
// and reports the run length and the index where the run ended.
module posit_regime_scanner
   import posit_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int RS = log2(N_DEF)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic          special_i,
   input  logic [N-2:0]  rem_i,
   output logic          done_o,
   output logic [RS-1:0] run_o,
   output logic [RS-1:0] term_o
);
   logic          busy_q;
   logic [RS-1:0] idx_q, run_q, term_q;
   logic          match, hit;
   assign match  = rem_i[idx_q] == rem_i[N-2];
   // An exhausted run ends at index 0, which leaves no exponent bits, same as a terminator there
   assign hit    = busy_q && (special_i || !match || idx_q == '0);
   assign done_o = !busy_q || hit;
   assign run_o  = run_q;
   assign term_o = term_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         idx_q  <= '0;
         run_q  <= '0;
         term_q <= '0;
      end else if (start_i) begin
         busy_q <= 1'b1;
         idx_q  <= RS'(N - 2);
         run_q  <= '0;
      end else if (busy_q) begin
         if (!special_i && match) run_q <= run_q + RS'(1);
         if (hit) begin
            busy_q <= 1'b0;
            term_q <= idx_q;
         end else begin
            idx_q <= idx_q - RS'(1);
         end
      end
   end
endmodule

// File: rtl/posit_operand_decoder.sv
// posit_operand_decoder: two-operand posit field decoder feeding the adder
// alignment stage; regime runs are scanned serially, fields are registered.
module posit_operand_decoder
   import posit_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int ES = ES_DEF,
   parameter int RS = log2(N)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [N-1:0]        In1,
   input  logic [N-1:0]        In2,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                Sign1,
   output logic                Sign2,
   output logic [N-2:0]        InRemain1,
   output logic [N-2:0]        InRemain2,
   output logic signed [RS:0]  RegimeValue1,
   output logic signed [RS:0]  RegimeValue2,
   output logic [ES-1:0]       Exponent1,
   output logic [ES-1:0]       Exponent2,
   output logic [N-ES+2:0]     Mantissa1,
   output logic [N-ES+2:0]     Mantissa2,
   output logic                IsZero1,
   output logic                IsZero2,
   output logic                IsNaR1,
   output logic                IsNaR2
);
   localparam int MW = N - ES + 3;
   dec_state_e         state_q, state_d;
   logic               accept;
   logic [1:0]         sign_q, zero_q, nar_q, done_w;
   logic [1:0][N-1:0]  in_w;
   logic [1:0][N-2:0]  abs_w, rem_q, sh_w;
   logic [1:0][RS-1:0] run_w, term_w;
   logic [1:0][RS:0]   k_q, k_w;
   logic [1:0][ES-1:0] exp_q, exp_w;
   logic [1:0][MW-1:0] mant_q, mant_w;
   assign in_w      = {In2, In1};
   assign accept    = state_q == IDLE && in_valid;
   assign in_ready  = rst_n && state_q == IDLE;
   assign out_valid = state_q == DONE;
   always_comb begin
      state_d = state_q == IDLE    ? (in_valid ? SCAN : IDLE)
              : state_q == SCAN    ? (&done_w ? EXTRACT : SCAN)
              : state_q == EXTRACT ? DONE
              : (out_ready ? IDLE : DONE);
   end
   for (genvar i = 0; i < 2; i++) begin : g_op
      logic special;
      assign special   = zero_q[i] | nar_q[i];
      assign abs_w[i]  = in_w[i][N-1] ? -in_w[i][N-2:0] : in_w[i][N-2:0];
      // Slide the bits after the terminator up to the MSB: exponent on top, fraction below
      assign sh_w[i]   = rem_q[i] << (RS'(N - 1) - term_w[i]);
      assign k_w[i]    = special ? '0
                       : rem_q[i][N-2] ? {1'b0, run_w[i]} - (RS+1)'(1)
                       : -{1'b0, run_w[i]};
      assign exp_w[i]  = special ? '0 : sh_w[i][N-2 -: ES];
      assign mant_w[i] = special ? '0 : {2'b00, 1'b1, sh_w[i][N-2-ES:0], 1'b0};
      posit_regime_scanner #(.N(N), .RS(RS)) u_scan (
         .clk       (clk),
         .rst_n     (rst_n),
         .start_i   (accept),
         .special_i (special),
         .rem_i     (rem_q[i]),
         .done_o    (done_w[i]),
         .run_o     (run_w[i]),
         .term_o    (term_w[i])
      );
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sign_q  <= '0;
         zero_q  <= '0;
         nar_q   <= '0;
         rem_q   <= '0;
         k_q     <= '0;
         exp_q   <= '0;
         mant_q  <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            for (int j = 0; j < 2; j++) begin
               sign_q[j] <= in_w[j][N-1];
               rem_q[j]  <= abs_w[j];
               zero_q[j] <= in_w[j] == '0;
               nar_q[j]  <= in_w[j] == {1'b1, {(N-1){1'b0}}};
            end
         end
         if (state_q == EXTRACT) begin
            k_q    <= k_w;
            exp_q  <= exp_w;
            mant_q <= mant_w;
         end
      end
   end
   assign Sign1        = sign_q[0];
   assign Sign2        = sign_q[1];
   assign InRemain1    = rem_q[0];
   assign InRemain2    = rem_q[1];
   assign RegimeValue1 = k_q[0];
   assign RegimeValue2 = k_q[1];
   assign Exponent1    = exp_q[0];
   assign Exponent2    = exp_q[1];
   assign Mantissa1    = mant_q[0];
   assign Mantissa2    = mant_q[1];
   assign IsZero1      = zero_q[0];
   assign IsZero2      = zero_q[1];
   assign IsNaR1       = nar_q[0];
   assign IsNaR2       = nar_q[1];
endmodule

// File: tb/tb_posit_operand_decoder.sv
// tb_posit_operand_decoder: constant vector table, model-driven random pairs,
// backpressure and mid-scan reset sequences, all checked through a scoreboard queue.
module tb_posit_operand_decoder;
   typedef struct packed {
      logic       sg;
      logic [6:0] rem;
      logic [3:0] k;
      logic [2:0] e;
      logic [7:0] m;
      logic       z;
      logic       n;
   } op_t;
   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] s;
      op_t        o1;
      op_t        o2;
   } vec_t;

   logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [7:0] In1 = '0, In2 = '0;
   logic       in_ready, out_valid, Sign1, Sign2, IsZero1, IsZero2, IsNaR1, IsNaR2;
   logic [6:0] InRemain1, InRemain2;
   logic [3:0] RegimeValue1, RegimeValue2;
   logic [2:0] Exponent1, Exponent2;
   logic [7:0] Mantissa1, Mantissa2;
   int         checks = 0, errors = 0;
   vec_t       sbq[$];
   vec_t       tbl[7];

   always #5 clk = ~clk;

   posit_operand_decoder #(.N(8), .ES(3), .RS(3)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .In1          (In1),
      .In2          (In2),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .Sign1        (Sign1),
      .Sign2        (Sign2),
      .InRemain1    (InRemain1),
      .InRemain2    (InRemain2),
      .RegimeValue1 (RegimeValue1),
      .RegimeValue2 (RegimeValue2),
      .Exponent1    (Exponent1),
      .Exponent2    (Exponent2),
      .Mantissa1    (Mantissa1),
      .Mantissa2    (Mantissa2),
      .IsZero1      (IsZero1),
      .IsZero2      (IsZero2),
      .IsNaR1       (IsNaR1),
      .IsNaR2       (IsNaR2)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, want);
      end
   endtask

   function automatic op_t dut_op(input int j);
      return j == 0 ? {Sign1, InRemain1, RegimeValue1, Exponent1, Mantissa1, IsZero1, IsNaR1}
                    : {Sign2, InRemain2, RegimeValue2, Exponent2, Mantissa2, IsZero2, IsNaR2};
   endfunction

   function automatic op_t mkop(input logic sg, input logic [6:0] rem, input int k,
                                input logic [2:0] e, input logic [7:0] m, input logic z, input logic n);
      return {sg, rem, 4'(k), e, m, z, n};
   endfunction

   function automatic vec_t mkv(input logic [7:0] a, input logic [7:0] b, input int s,
                                input op_t o1, input op_t o2);
      return {a, b, 4'(s), o1, o2};
   endfunction

   // Reference decode: walk the run bit by bit, then read exponent and fraction bits after it
   function automatic op_t model(input logic [7:0] x, output int c);
      logic [7:0] a;
      logic [2:0] e;
      logic [4:0] f;
      op_t        o;
      int         i, r;
      a = x[7] ? 8'(8'd0 - x) : x;
      o = '0;
      o.sg = x[7];
      o.rem = a[6:0];
      o.z = x == 8'h00;
      o.n = x == 8'h80;
      c = 1;
      if (o.z || o.n) return o;
      i = 6;
      r = 0;
      while (i >= 0 && a[i] == a[6]) begin
         r++;
         i--;
      end
      c = (r + 1 > 7) ? 7 : r + 1;
      o.k = a[6] ? 4'(r - 1) : 4'(-r);
      e = '0;
      f = '0;
      for (int j = 0; j < 3; j++) e = {e[1:0], (i - 1 - j >= 0) ? a[i-1-j] : 1'b0};
      for (int j = 0; j < 5; j++) f = {f[3:0], (i - 4 - j >= 0) ? a[i-4-j] : 1'b0};
      o.e = e;
      o.m = {3'b001, f};
      return o;
   endfunction

   function automatic vec_t mkvec(input logic [7:0] a, input logic [7:0] b);
      int  c1, c2;
      op_t o1, o2;
      o1 = model(a, c1);
      o2 = model(b, c2);
      return mkv(a, b, c1 > c2 ? c1 : c2, o1, o2);
   endfunction

   task automatic send(input logic [7:0] a, input logic [7:0] b, input vec_t e);
      int n = 0;
      @(negedge clk);
      In1 = a;
      In2 = b;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 64'(n < 50), 1);
      sbq.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Entered one edge after the accepting edge
   task automatic recv();
      vec_t e;
      int   lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      e = sbq.pop_front();
      chk($sformatf("out_valid %h/%h", e.a, e.b), 64'(out_valid), 1);
      chk($sformatf("latency %h/%h", e.a, e.b), lat, e.s + 2);
      chk($sformatf("in_ready_done %h/%h", e.a, e.b), 64'(in_ready), 0);
      chk($sformatf("op1 %h/%h", e.a, e.b), dut_op(0), e.o1);
      chk($sformatf("op2 %h/%h", e.a, e.b), dut_op(1), e.o2);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        e, bp;
      int          lat;
      logic [63:0] snap;
      tbl[0] = mkv(8'h40, 8'h48, 2, mkop(1'b0, 7'h40, 0, 3'd0, 8'h20, 1'b0, 1'b0),
                                    mkop(1'b0, 7'h48, 0, 3'd2, 8'h20, 1'b0, 1'b0));
      tbl[1] = mkv(8'hC0, 8'h10, 3, mkop(1'b1, 7'h40, 0, 3'd0, 8'h20, 1'b0, 1'b0),
                                    mkop(1'b0, 7'h10, -2, 3'd0, 8'h20, 1'b0, 1'b0));
      tbl[2] = mkv(8'h7F, 8'h01, 7, mkop(1'b0, 7'h7F, 6, 3'd0, 8'h20, 1'b0, 1'b0),
                                    mkop(1'b0, 7'h01, -6, 3'd0, 8'h20, 1'b0, 1'b0));
      tbl[3] = mkv(8'h00, 8'h80, 1, mkop(1'b0, 7'h00, 0, 3'd0, 8'h00, 1'b1, 1'b0),
                                    mkop(1'b1, 7'h00, 0, 3'd0, 8'h00, 1'b0, 1'b1));
      tbl[4] = mkv(8'h5B, 8'hA5, 2, mkop(1'b0, 7'h5B, 0, 3'd6, 8'h38, 1'b0, 1'b0),
                                    mkop(1'b1, 7'h5B, 0, 3'd6, 8'h38, 1'b0, 1'b0));
      tbl[5] = mkv(8'h06, 8'h3F, 5, mkop(1'b0, 7'h06, -4, 3'd4, 8'h20, 1'b0, 1'b0),
                                    mkop(1'b0, 7'h3F, -1, 3'd7, 8'h38, 1'b0, 1'b0));
      tbl[6] = mkv(8'hFF, 8'h70, 7, mkop(1'b1, 7'h01, -6, 3'd0, 8'h20, 1'b0, 1'b0),
                                    mkop(1'b0, 7'h70, 2, 3'd0, 8'h20, 1'b0, 1'b0));
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 0);
      chk("rst_out_valid", 64'(out_valid), 0);
      chk("rst_fields", {dut_op(0), dut_op(1)}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 1);
      foreach (tbl[t]) begin
         send(tbl[t].a, tbl[t].b, tbl[t]);
         recv();
      end
      repeat (20) begin : g_rand
         logic [7:0] a, b;
         a = 8'($urandom);
         b = 8'($urandom);
         send(a, b, mkvec(a, b));
         recv();
      end
      // Backpressure: fields must hold while a competing pair waits at the input
      out_ready = 1'b0;
      bp = mkvec(8'h5B, 8'h06);
      send(8'h5B, 8'h06, bp);
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      e = sbq.pop_front();
      chk("bp_latency", lat, e.s + 2);
      chk("bp_op1", dut_op(0), e.o1);
      chk("bp_op2", dut_op(1), e.o2);
      snap = {dut_op(0), dut_op(1)};
      In1 = 8'h11;
      In2 = 8'h22;
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold", {dut_op(0), dut_op(1)}, snap);
         chk("bp_in_ready", 64'(in_ready), 0);
         chk("bp_out_valid", 64'(out_valid), 1);
      end
      sbq.push_back(mkvec(8'h11, 8'h22));
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_valid", 64'(out_valid), 0);
      chk("bp_release_ready", 64'(in_ready), 1);
      @(negedge clk);
      in_valid = 1'b0;
      recv();
      // Reset in the middle of a long scan
      send(8'h7F, 8'h01, mkvec(8'h7F, 8'h01));
      e = sbq.pop_back();
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_out_valid", 64'(out_valid), 0);
      chk("abort_in_ready", 64'(in_ready), 0);
      chk("abort_fields", {dut_op(0), dut_op(1)}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_idle", 64'(in_ready), 1);
      send(8'h40, 8'h40, mkvec(8'h40, 8'h40));
      recv();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/posit_operand_decoder.md
# posit_operand_decoder

Sequential two-operand posit decoder that sits directly upstream of the posit adder alignment stage. It accepts two N-bit posits over a valid/ready handshake and takes absolute values of negative operands. It scans each regime run one bit per cycle and extracts exponent and hidden-bit mantissa. It then presents registered Sign/InRemain/RegimeValue/Exponent/Mantissa fields in exactly the form alignment consumes.

## Interface
- N, 8: posit width
- ES, 3: exponent field width
- RS, log2(N): regime value width minus one (RegimeValue is RS+1 bits signed)
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  decoder can accept a pair
- In1, In2  in  N  raw posit operands
- out_valid  out  1  decoded fields valid
- out_ready  in  1  downstream accepts fields
- Sign1, Sign2  out  1  posit sign bit
- InRemain1, InRemain2  out  N-1  bits [N-2:0] of |In| (two's complement applied when sign=1)
- RegimeValue1, RegimeValue2  out  RS+1 signed  k
- Exponent1, Exponent2  out  ES  exponent field
- Mantissa1, Mantissa2  out  N-ES+3  {2'b00, 1'b1, fraction left-aligned in N-ES bits, zero-filled}
- IsZero1, IsZero2, IsNaR1, IsNaR2  out  1  special-value flags

## Operation
- FSM states: IDLE, SCAN, EXTRACT, DONE.
- IDLE: in_ready=1. On in_valid, capture |In| and sign for each operand, flag specials, and go to SCAN.
  - Zero: In == 0.
  - NaR: In == 1 followed by N-1 zeros.
- SCAN: per operand, an index starts at N-2 and drops by 1 each cycle. The operand terminates on whichever comes first:
  - the first bit that differs from R[N-2] (the terminator), or
  - index 0 (exhausted).
- Special operands are terminated immediately.
- Per-operand cycles c = min(r+1, N-1), where r is the leading run length. Specials count as 1. SCAN lasts max(c1,c2) cycles.
- k = r-1 if R[N-2]=1, else -r.
- EXTRACT, 1 cycle: exponent = the ES bits following the terminator. Missing LSBs beyond bit 0 are zero-filled. Fraction = the remaining bits, left-aligned.
- Specials output: RegimeValue=0, Exponent=0, Mantissa=0. InRemain is still |In|[N-2:0], and Sign is still the raw sign.
- DONE: out_valid=1. All outputs hold stable until out_ready.
  - out_ready=1: go to IDLE.
  - No same-cycle accept in DONE; in_ready=0.
- Reset values: out_valid=0, in_ready=0 while rst_n=0 and 1 in IDLE afterward. All field outputs and flags are 0, and the FSM is in IDLE.
- rst_n low in any state aborts the operation within one cycle. No partial result is ever presented.

## Timing
- Accept at edge T, then SCAN during cycles T+1..T+S, where S=max(c1,c2) with 1≤S≤N-1.
- EXTRACT occurs at T+S+1. out_valid rises at T+S+2.
- Throughput: one pair per S+3 cycles minimum (the IDLE cycle is required).
- Outputs are registered; no combinational path from In1/In2 or out_ready to any field output.
- in_valid while in_ready=0 is ignored; the source holds it.

## Structure
- Shared package posit_pkg holds the following, reused by alignment and later stages:
  - the log2 function
  - default N/ES
  - the mantissa width localparam N-ES+3
  - the decoder state enum
- Sub-module posit_regime_scanner, instantiated twice:
  - Inputs: start, the remaining bits, special flag.
  - Outputs: done, run length r, terminator index.
  - The top holds the FSM, handshake, and extraction/output registers.

## Test plan
- In1=0x40, In2=0x48, out_ready=1 -> out_valid at T+4 (S=2).
  - Operand 1: Sign 0, InRemain 0x40, k=0, Exponent 0, Mantissa 0x20.
  - Operand 2: k=0, Exponent 2, Mantissa 0x20.
- In1=0xC0, In2=0x10 -> out_valid at T+5 (S=3).
  - Operand 1: Sign1=1, InRemain1=0x40, k=0.
  - Operand 2: k=-2, Exponent 0, Mantissa 0x20.
- In1=0x7F, In2=0x01 -> S=7, out_valid at T+9.
  - k1=6, k2=-6, Exponents 0, Mantissa 0x20.
- In1=0x00, In2=0x80 -> IsZero1=1, IsNaR2=1, all other fields 0 (InRemain2=0), S=1, out_valid at T+3.
- Backpressure: out_ready=0 for 5 cycles in DONE -> outputs bit-stable, in_ready=0, a new in_valid is ignored. Release -> IDLE, then the next pair is accepted.
- rst_n low during SCAN of 0x7F/0x01 -> next cycle out_valid=0, all outputs 0, IDLE. The following pair 0x40/0x40 decodes correctly.
